// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width and divider FSM states.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div16_seq_if.sv
// Start/busy/done handshake and operand/result bus for the iterative divider.
interface div16_seq_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  // Requester side (control unit).
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  // Divider side.
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div16_seq_step.sv
// One restoring shift-subtract iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             q_msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] trial;

  // The remainder is always below the divisor, so its top bit never carries
  // information into the next step.
  logic unused_rem_msb;
  assign unused_rem_msb = rem_i[WIDTH];

  // Compare-and-subtract on the shifted remainder.
  always_comb begin
    trial = {rem_i[WIDTH-1:0], q_msb_i};
    if (trial >= {1'b0, divisor_i}) begin
      rem_o   = trial - {1'b0, divisor_i};
      q_bit_o = 1'b1;
    end else begin
      rem_o   = trial;
      q_bit_o = 1'b0;
    end
  end

endmodule

// File: rtl/div16_seq.sv
// Iterative unsigned divider: one quotient bit per clock, quotient and
// remainder delivered together with a one-cycle done pulse.
module div16_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned CNT_W = 5
) (
  input  logic     clk,
  input  logic     rst,
  div16_seq_if.slave bus
);

  div_state_t       state_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH:0]   r_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic             dbz_q;

  logic [WIDTH:0]   r_next;
  logic             q_bit;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i    (r_q),
    .q_msb_i  (q_q[WIDTH-1]),
    .divisor_i(d_q),
    .rem_o    (r_next),
    .q_bit_o  (q_bit)
  );

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

  // Control FSM, iteration registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            if (bus.divisor != '0) begin
              q_q     <= bus.dividend;
              d_q     <= bus.divisor;
              r_q     <= '0;
              cnt_q   <= '0;
              state_q <= RUN;
            end else begin
              // Zero divisor skips the loop, matching the modulo unit's result.
              quot_q  <= '0;
              rem_q   <= '0;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        RUN: begin
          q_q   <= {q_q[WIDTH-2:0], q_bit};
          r_q   <= r_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            quot_q  <= {q_q[WIDTH-2:0], q_bit};
            rem_q   <= r_next[WIDTH-1:0];
            dbz_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div16_seq.sv
// Randomized and directed checks of div16_seq against a plain / and % model.
module tb_div16_seq;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  div16_seq_if #(.WIDTH(16)) bus ();

  div16_seq #(
    .WIDTH(16),
    .CNT_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void ref_div(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output logic z);
    if (b == 16'd0) begin
      q = 16'd0;
      r = 16'd0;
      z = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endfunction

  // Present operands with a one-cycle start; scramble operands after acceptance.
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = 16'($urandom);
    bus.divisor  = 16'($urandom);
  endtask

  // Negedges waited until done is seen (40 means it never came).
  task automatic wait_done(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    bus.start = 1'b0;
    bus.dividend = 16'd0;
    bus.divisor = 16'd0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: busy/done/dbz=%b expected 000",
               {bus.busy, bus.done, bus.div_by_zero});
    end
    checks++;
    if ({bus.quotient, bus.remainder} !== 32'd0) begin
      errors++;
      $display("FAIL reset_results: q=%h r=%h expected 0 0", bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_directed;
    logic [15:0] ta [8] = '{16'd8, 16'hFFFF, 16'd1, 16'd0, 16'd1234, 16'hFFFF, 16'd0, 16'd100};
    logic [15:0] tb [8] = '{16'd3, 16'h0001, 16'd2, 16'd1, 16'd0, 16'hFFFF, 16'd0, 16'd7};
    logic [15:0] eq, er;
    logic ez;
    int n;
    for (int i = 0; i < 8; i++) begin
      ref_div(ta[i], tb[i], eq, er, ez);
      issue(ta[i], tb[i]);
      checks++;
      if (bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL dir_busy[%0d]: busy=%b expected 1", i, bus.busy);
      end
      wait_done(n);
      checks++;
      if (n !== ((tb[i] == 16'd0) ? 0 : 16)) begin
        errors++;
        $display("FAIL dir_latency[%0d]: waited %0d expected %0d", i, n,
                 (tb[i] == 16'd0) ? 0 : 16);
      end
      checks++;
      if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {eq, er, ez}) begin
        errors++;
        $display("FAIL dir_result[%0d] %0d/%0d: q=%0d r=%0d z=%b expected q=%0d r=%0d z=%b",
                 i, ta[i], tb[i], bus.quotient, bus.remainder, bus.div_by_zero, eq, er, ez);
      end
      @(negedge clk);
      checks++;
      if ({bus.done, bus.busy} !== 2'b00) begin
        errors++;
        $display("FAIL dir_after_done[%0d]: done/busy=%b expected 00", i, {bus.done, bus.busy});
      end
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {eq, er, ez}) begin
        errors++;
        $display("FAIL dir_hold[%0d]: q=%0d r=%0d z=%b expected q=%0d r=%0d z=%b",
                 i, bus.quotient, bus.remainder, bus.div_by_zero, eq, er, ez);
      end
    end
  endtask

  task automatic test_start_ignored;
    int n;
    issue(16'd200, 16'd9);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = 16'd7;
    bus.divisor = 16'd0;
    repeat (2) @(negedge clk);
    bus.start = 1'b0;
    wait_done(n);
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL ign_latency: waited %0d expected 10", n);
    end
    checks++;
    if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {16'd22, 16'd2, 1'b0}) begin
      errors++;
      $display("FAIL ign_result: q=%0d r=%0d z=%b expected q=22 r=2 z=0",
               bus.quotient, bus.remainder, bus.div_by_zero);
    end
    repeat (4) @(negedge clk);
    checks++;
    if ({bus.busy, bus.quotient, bus.remainder, bus.div_by_zero} !== {1'b0, 16'd22, 16'd2, 1'b0})
    begin
      errors++;
      $display("FAIL ign_hold: busy=%b q=%0d r=%0d z=%b expected busy=0 q=22 r=2 z=0",
               bus.busy, bus.quotient, bus.remainder, bus.div_by_zero);
    end
  endtask

  task automatic test_reset_mid_run;
    int n;
    bit seen;
    issue(16'd50000, 16'd3);
    repeat (6) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== 35'd0) begin
      errors++;
      $display("FAIL midrst_outputs: busy=%b done=%b q=%0d r=%0d z=%b expected all 0",
               bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_done: done seen=%b expected 0", seen);
    end
    issue(16'd100, 16'd7);
    wait_done(n);
    checks++;
    if ({n[5:0], bus.quotient, bus.remainder} !== {6'd16, 16'd14, 16'd2}) begin
      errors++;
      $display("FAIL midrst_fresh: wait=%0d q=%0d r=%0d expected wait=16 q=14 r=2",
               n, bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] a, b, eq, er;
    logic ez;
    int n;
    @(negedge clk);
    a = 16'($urandom);
    b = 16'($urandom_range(1, 65535));
    bus.dividend = a;
    bus.divisor = b;
    bus.start = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ref_div(a, b, eq, er, ez);
      if (i != 0) @(negedge clk);
      wait_done(n);
      checks++;
      if (n >= 40) begin
        errors++;
        $display("FAIL b2b_timeout[%0d]: no done within 40 cycles", i);
        break;
      end
      if (i != 0) begin
        checks++;
        if (n + 1 !== 18) begin
          errors++;
          $display("FAIL b2b_spacing[%0d]: spacing %0d expected 18", i, n + 1);
        end
      end
      checks++;
      if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {eq, er, ez}) begin
        errors++;
        $display("FAIL b2b_result[%0d] %0d/%0d: q=%0d r=%0d z=%b expected q=%0d r=%0d z=%b",
                 i, a, b, bus.quotient, bus.remainder, bus.div_by_zero, eq, er, ez);
      end
      a = 16'($urandom);
      b = 16'($urandom_range(1, 65535));
      bus.dividend = a;
      bus.divisor = b;
      if (i == 999) bus.start = 1'b0;
    end
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    test_reset();
    test_directed();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
